// File: rtl/glb_iact_bank.sv
`default_nettype none
// ============================================================================
//  Module   : glb_iact_bank
//  Purpose  : One GLB input-activation bank. Stores a CSC-compressed iact
//             tile (data + address streams) on a write request, then replays
//             it to the PE cluster on a read request.
//  Revision : 1.0 - initial release
// ============================================================================
module glb_iact_bank #(
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 7,
    parameter int DATA_DEPTH = 32,
    parameter int ADDR_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_en,
    output logic              write_done,
    input  logic              read_en,
    output logic              read_done,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_data_last,
    input  logic              in_data_valid,
    output logic              in_data_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_addr_last,
    input  logic              in_addr_valid,
    output logic              in_addr_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_data_last,
    output logic              out_data_valid,
    input  logic              out_data_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_addr_last,
    output logic              out_addr_valid,
    input  logic              out_addr_ready,
    output logic              overflow
);

    // Pointers/lengths must be able to hold DEPTH itself (the "full" value).
    localparam int c_DPW = $clog2(DATA_DEPTH + 1);
    localparam int c_APW = $clog2(ADDR_DEPTH + 1);
    localparam int c_DIW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int c_AIW = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1;

    localparam logic [c_DPW-1:0] c_DATA_FULL = c_DPW'(DATA_DEPTH);
    localparam logic [c_APW-1:0] c_ADDR_FULL = c_APW'(ADDR_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WRITE = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_REARM = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic [DATA_W-1:0] r_data_mem [DATA_DEPTH];
    logic [ADDR_W-1:0] r_addr_mem [ADDR_DEPTH];

    logic [c_DPW-1:0]  r_wr_ptr_data;
    logic [c_APW-1:0]  r_wr_ptr_addr;
    logic [c_DPW-1:0]  r_len_data;
    logic [c_APW-1:0]  r_len_addr;
    logic [c_DPW-1:0]  r_rd_ptr_data;
    logic [c_APW-1:0]  r_rd_ptr_addr;
    logic              r_data_fin;
    logic              r_addr_fin;
    logic              r_overflow;
    logic              r_write_done;
    logic              r_read_done;

    logic              w_in_data_ready;
    logic              w_in_addr_ready;
    logic              w_out_data_valid;
    logic              w_out_addr_valid;

    logic              w_data_hs;
    logic              w_addr_hs;
    logic              w_data_full;
    logic              w_addr_full;
    logic              w_data_fin_nx;
    logic              w_addr_fin_nx;
    logic              w_wr_both;

    logic              w_out_data_hs;
    logic              w_out_addr_hs;
    logic [c_DPW-1:0]  w_rd_ptr_data_nx;
    logic [c_APW-1:0]  w_rd_ptr_addr_nx;
    logic [c_DPW-1:0]  w_len_data_m1;
    logic [c_APW-1:0]  w_len_addr_m1;
    logic              w_rd_done;

    // Write-side handshakes and completion detection
    assign w_data_hs     = in_data_valid & w_in_data_ready;
    assign w_addr_hs     = in_addr_valid & w_in_addr_ready;
    assign w_data_full   = (r_wr_ptr_data == c_DATA_FULL);
    assign w_addr_full   = (r_wr_ptr_addr == c_ADDR_FULL);
    assign w_data_fin_nx = r_data_fin | (w_data_hs & in_data_last);
    assign w_addr_fin_nx = r_addr_fin | (w_addr_hs & in_addr_last);
    assign w_wr_both     = w_data_fin_nx & w_addr_fin_nx;

    // Read-side handshakes; completion looks at post-handshake pointers so
    // read_done lands one cycle after the final word is taken.
    assign w_out_data_hs    = w_out_data_valid & out_data_ready;
    assign w_out_addr_hs    = w_out_addr_valid & out_addr_ready;
    assign w_rd_ptr_data_nx = r_rd_ptr_data + c_DPW'(w_out_data_hs);
    assign w_rd_ptr_addr_nx = r_rd_ptr_addr + c_APW'(w_out_addr_hs);
    assign w_len_data_m1    = r_len_data - c_DPW'(1);
    assign w_len_addr_m1    = r_len_addr - c_APW'(1);
    assign w_rd_done        = read_en
                            & (w_rd_ptr_data_nx >= r_len_data)
                            & (w_rd_ptr_addr_nx >= r_len_addr);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; write_en wins over read_en in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (write_en) begin
                    w_state_next = c_WRITE;
                end else if (read_en) begin
                    w_state_next = c_READ;
                end
            end
            c_WRITE: begin
                if (w_wr_both) begin
                    w_state_next = c_IDLE;
                end
            end
            c_READ: begin
                if (w_rd_done) begin
                    w_state_next = c_REARM;
                end
            end
            c_REARM: begin
                if (!read_en) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // State-decoded handshake outputs; a dropped read_en pauses the stream
    always_comb begin
        w_in_data_ready  = 1'b0;
        w_in_addr_ready  = 1'b0;
        w_out_data_valid = 1'b0;
        w_out_addr_valid = 1'b0;
        case (r_state)
            c_WRITE: begin
                w_in_data_ready = ~r_data_fin;
                w_in_addr_ready = ~r_addr_fin;
            end
            c_READ: begin
                w_out_data_valid = read_en & (r_rd_ptr_data < r_len_data);
                w_out_addr_valid = read_en & (r_rd_ptr_addr < r_len_addr);
            end
            default: begin
                w_in_data_ready  = 1'b0;
                w_in_addr_ready  = 1'b0;
            end
        endcase
    end

    // Pointers, lengths, fin flags, sticky overflow and registered done pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr_data <= '0;
            r_wr_ptr_addr <= '0;
            r_len_data    <= '0;
            r_len_addr    <= '0;
            r_rd_ptr_data <= '0;
            r_rd_ptr_addr <= '0;
            r_data_fin    <= 1'b0;
            r_addr_fin    <= 1'b0;
            r_overflow    <= 1'b0;
            r_write_done  <= 1'b0;
            r_read_done   <= 1'b0;
        end else begin
            r_write_done <= 1'b0;
            r_read_done  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (write_en) begin
                        r_wr_ptr_data <= '0;
                        r_wr_ptr_addr <= '0;
                        r_data_fin    <= 1'b0;
                        r_addr_fin    <= 1'b0;
                        r_overflow    <= 1'b0;
                    end else if (read_en) begin
                        r_rd_ptr_data <= '0;
                        r_rd_ptr_addr <= '0;
                    end
                end
                c_WRITE: begin
                    if (w_data_hs) begin
                        if (w_data_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_wr_ptr_data <= r_wr_ptr_data + c_DPW'(1);
                        end
                        if (in_data_last) begin
                            r_data_fin <= 1'b1;
                            r_len_data <= w_data_full ? c_DATA_FULL
                                                      : r_wr_ptr_data + c_DPW'(1);
                        end
                    end
                    if (w_addr_hs) begin
                        if (w_addr_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_wr_ptr_addr <= r_wr_ptr_addr + c_APW'(1);
                        end
                        if (in_addr_last) begin
                            r_addr_fin <= 1'b1;
                            r_len_addr <= w_addr_full ? c_ADDR_FULL
                                                      : r_wr_ptr_addr + c_APW'(1);
                        end
                    end
                    if (w_wr_both) begin
                        r_write_done <= 1'b1;
                    end
                end
                c_READ: begin
                    r_rd_ptr_data <= w_rd_ptr_data_nx;
                    r_rd_ptr_addr <= w_rd_ptr_addr_nx;
                    if (w_rd_done) begin
                        r_read_done <= 1'b1;
                    end
                end
                default: begin
                    r_write_done <= 1'b0;
                end
            endcase
        end
    end

    // Tile storage; beats arriving with the array full are dropped
    always_ff @(posedge clock) begin
        if (w_data_hs && !w_data_full) begin
            r_data_mem[r_wr_ptr_data[c_DIW-1:0]] <= in_data;
        end
        if (w_addr_hs && !w_addr_full) begin
            r_addr_mem[r_wr_ptr_addr[c_AIW-1:0]] <= in_addr;
        end
    end

    // Stored words are only exposed while valid so idle outputs read as 0
    assign out_data       = w_out_data_valid ? r_data_mem[r_rd_ptr_data[c_DIW-1:0]] : '0;
    assign out_addr       = w_out_addr_valid ? r_addr_mem[r_rd_ptr_addr[c_AIW-1:0]] : '0;
    assign out_data_last  = w_out_data_valid & (r_rd_ptr_data == w_len_data_m1);
    assign out_addr_last  = w_out_addr_valid & (r_rd_ptr_addr == w_len_addr_m1);
    assign out_data_valid = w_out_data_valid;
    assign out_addr_valid = w_out_addr_valid;
    assign in_data_ready  = w_in_data_ready;
    assign in_addr_ready  = w_in_addr_ready;
    assign write_done     = r_write_done;
    assign read_done      = r_read_done;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_glb_iact_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glb_iact_bank
//  Purpose  : Directed self-checking bench for glb_iact_bank.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_glb_iact_bank;

    localparam int DATA_W     = 12;
    localparam int ADDR_W     = 7;
    localparam int DATA_DEPTH = 32;
    localparam int ADDR_DEPTH = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              write_en;
    logic              write_done;
    logic              read_en;
    logic              read_done;
    logic [DATA_W-1:0] in_data;
    logic              in_data_last;
    logic              in_data_valid;
    logic              in_data_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              in_addr_last;
    logic              in_addr_valid;
    logic              in_addr_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_data_last;
    logic              out_data_valid;
    logic              out_data_ready;
    logic [ADDR_W-1:0] out_addr;
    logic              out_addr_last;
    logic              out_addr_valid;
    logic              out_addr_ready;
    logic              overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] exp_d[$];
    logic [ADDR_W-1:0] exp_a[$];
    logic [DATA_W-1:0] got_d[$];
    logic              got_dl[$];
    logic [ADDR_W-1:0] got_a[$];
    logic              got_al[$];

    glb_iact_bank #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DATA_DEPTH(DATA_DEPTH),
        .ADDR_DEPTH(ADDR_DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .write_en      (write_en),
        .write_done    (write_done),
        .read_en       (read_en),
        .read_done     (read_done),
        .in_data       (in_data),
        .in_data_last  (in_data_last),
        .in_data_valid (in_data_valid),
        .in_data_ready (in_data_ready),
        .in_addr       (in_addr),
        .in_addr_last  (in_addr_last),
        .in_addr_valid (in_addr_valid),
        .in_addr_ready (in_addr_ready),
        .out_data      (out_data),
        .out_data_last (out_data_last),
        .out_data_valid(out_data_valid),
        .out_data_ready(out_data_ready),
        .out_addr      (out_addr),
        .out_addr_last (out_addr_last),
        .out_addr_valid(out_addr_valid),
        .out_addr_ready(out_addr_ready),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One write cycle with optional data/addr beats; valids drop afterwards
    task automatic beat(input bit dv, input logic [DATA_W-1:0] d, input bit dl,
                        input bit av, input logic [ADDR_W-1:0] a, input bit al);
        in_data_valid = dv; in_data = d; in_data_last = dl;
        in_addr_valid = av; in_addr = a; in_addr_last = al;
        tick();
        in_data_valid = 1'b0; in_data_last = 1'b0;
        in_addr_valid = 1'b0; in_addr_last = 1'b0;
    endtask

    task automatic start_write();
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    // Full read episode from IDLE, compared against exp_d / exp_a
    task automatic run_read(input string name, input bit toggle);
        int done_cnt;
        int done_cyc;
        int last_hs;
        int cyc;
        got_d.delete(); got_dl.delete(); got_a.delete(); got_al.delete();
        done_cnt = 0; done_cyc = -1; last_hs = -2; cyc = 0;
        read_en = 1'b1;
        while (done_cnt == 0 && cyc < 60) begin
            out_data_ready = toggle ? cyc[0] : 1'b1;
            out_addr_ready = 1'b1;
            #1;
            if (read_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_data_valid && out_data_ready) begin
                got_d.push_back(out_data); got_dl.push_back(out_data_last); last_hs = cyc;
            end
            if (out_addr_valid && out_addr_ready) begin
                got_a.push_back(out_addr); got_al.push_back(out_addr_last); last_hs = cyc;
            end
            tick();
            cyc++;
        end
        // read_en held one extra cycle after read_done
        #1;
        if (read_done) done_cnt++;
        check({name, "_valid_rearm"}, {31'd0, out_data_valid | out_addr_valid}, 32'd0);
        read_en = 1'b0;
        tick();
        #1;
        if (read_done) done_cnt++;
        tick();
        out_data_ready = 1'b0;
        out_addr_ready = 1'b0;
        check({name, "_done_cnt"}, done_cnt, 1);
        check({name, "_done_lat"}, done_cyc, last_hs + 1);
        check({name, "_nd"}, got_d.size(), exp_d.size());
        check({name, "_na"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check({name, "_d"}, got_d[i], exp_d[i]);
            check({name, "_dlast"}, got_dl[i], (i == exp_d.size() - 1) ? 1 : 0);
        end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            check({name, "_a"}, got_a[i], exp_a[i]);
            check({name, "_alast"}, got_al[i], (i == exp_a.size() - 1) ? 1 : 0);
        end
    endtask

    initial begin
        reset = 1'b1; write_en = 1'b0; read_en = 1'b0;
        in_data = '0; in_data_last = 1'b0; in_data_valid = 1'b0;
        in_addr = '0; in_addr_last = 1'b0; in_addr_valid = 1'b0;
        out_data_ready = 1'b0; out_addr_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_wdone", write_done, 0);
        check("rst_rdone", read_done, 0);
        check("rst_dready", in_data_ready, 0);
        check("rst_aready", in_addr_ready, 0);
        check("rst_dvalid", out_data_valid, 0);
        check("rst_avalid", out_addr_valid, 0);
        check("rst_odata", out_data, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick();

        // Basic write: 3 data beats, 2 addr beats, addr finishes last
        start_write();
        check("wr_dready", in_data_ready, 1);
        check("wr_aready", in_addr_ready, 1);
        beat(1, 12'h101, 0, 1, 7'd1, 0);
        beat(1, 12'h202, 0, 0, 7'd0, 0);
        beat(1, 12'h303, 1, 0, 7'd0, 0);
        check("wr_wdone_early", write_done, 0);
        check("wr_dready_fin", in_data_ready, 0);
        check("wr_aready_open", in_addr_ready, 1);
        beat(0, 12'h000, 0, 1, 7'd3, 1);
        check("wr_wdone", write_done, 1);
        check("wr_ovf", overflow, 0);
        check("wr_aready_idle", in_addr_ready, 0);
        tick();
        check("wr_wdone_once", write_done, 0);

        // Read back, PE always ready, then with data backpressure (replay)
        exp_d = '{12'h101, 12'h202, 12'h303};
        exp_a = '{7'd1, 7'd3};
        run_read("rd1", 1'b0);
        run_read("rd_bp", 1'b1);

        // Overflow: 17 addr beats into 16 entries
        start_write();
        beat(1, 12'h7FF, 1, 1, 7'd1, 0);
        for (int i = 2; i <= 16; i++) beat(0, 12'h000, 0, 1, 7'(i), 0);
        check("ovf_before", overflow, 0);
        check("ovf_wdone_early", write_done, 0);
        beat(0, 12'h000, 0, 1, 7'd17, 1);
        check("ovf_set", overflow, 1);
        check("ovf_wdone", write_done, 1);
        tick();
        exp_d = '{12'h7FF};
        exp_a.delete();
        for (int i = 1; i <= 16; i++) exp_a.push_back(7'(i));
        run_read("rd_ovf", 1'b0);

        // Priority: write_en and read_en together enter WRITE; overflow clears
        write_en = 1'b1; read_en = 1'b1;
        tick();
        write_en = 1'b0; read_en = 1'b0;
        check("pri_dready", in_data_ready, 1);
        check("pri_aready", in_addr_ready, 1);
        check("pri_dvalid", out_data_valid, 0);
        check("pri_avalid", out_addr_valid, 0);
        check("pri_ovf_clr", overflow, 0);
        beat(1, 12'h055, 1, 1, 7'd9, 1);
        check("pri_wdone", write_done, 1);
        tick();

        // Reset in the middle of a write aborts with no done pulse
        start_write();
        beat(1, 12'h011, 0, 1, 7'd11, 0);
        beat(1, 12'h022, 0, 1, 7'd22, 0);
        reset = 1'b1;
        tick();
        check("mrst_dready", in_data_ready, 0);
        check("mrst_aready", in_addr_ready, 0);
        check("mrst_wdone", write_done, 0);
        check("mrst_ovf", overflow, 0);
        reset = 1'b0;
        tick();
        check("mrst_wdone2", write_done, 0);
        start_write();
        beat(1, 12'h0AA, 1, 1, 7'd5, 1);
        check("mrst_new_wdone", write_done, 1);
        tick();
        exp_d = '{12'h0AA};
        exp_a = '{7'd5};
        run_read("rd_mrst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/glb_iact_bank.md
Name: glb_iact_bank

Overview:
- One GLB input-activation bank: the responder side of the cluster-group controller's GLB iact write/read handshake.
- Loads a CSC-compressed iact tile from off-chip into two local arrays (data and address) on write_en, then pulses write_done.
- While read_en is high, streams the stored tile to the PE cluster and pulses read_done.
- Nine instances per cluster group, one per GLB iact slot.

Parameters:
DATA_W, 12, width of one CSC data word (8b value + 4b count)
ADDR_W, 7, width of one CSC address word
DATA_DEPTH, 32, data array entries
ADDR_DEPTH, 16, address array entries

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
write_en  in  1  one-cycle start-of-load pulse from controller
write_done  out  1  one-cycle pulse: both streams stored
read_en  in  1  level; held high until controller registers read_done
read_done  out  1  one-cycle pulse: both streams fully delivered
in_data  in  DATA_W  off-chip data beat
in_data_last  in  1  final data beat
in_data_valid  in  1  data beat valid
in_data_ready  out  1  bank accepts data beat
in_addr  in  ADDR_W  off-chip address beat
in_addr_last  in  1  final address beat
in_addr_valid  in  1  address beat valid
in_addr_ready  out  1  bank accepts address beat
out_data  out  DATA_W  data to PE
out_data_last  out  1  final stored data word
out_data_valid  out  1  data word valid
out_data_ready  in  1  PE accepts data
out_addr  out  ADDR_W  address to PE
out_addr_last  out  1  final stored address word
out_addr_valid  out  1  address word valid
out_addr_ready  in  1  PE accepts address
overflow  out  1  sticky: beat arrived with array full

Behaviour:
- Reset: state IDLE; all pointers/lengths 0; all outputs 0, including overflow. Array contents undefined. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, WRITE, READ, REARM.
- IDLE:
  - write_en -> WRITE next cycle; clear write pointers, data_fin/addr_fin and overflow.
  - Else read_en -> READ; clear read pointers.
  - write_en has priority over read_en.
- WRITE:
  - in_data_ready = ~data_fin; in_addr_ready = ~addr_fin.
  - Beat transfers on valid&ready and is written at its pointer; pointer increments.
  - A beat with last set sets the fin flag and records length = pointer+1.
  - Streams are independent and may finish in any order or in the same cycle.
  - Full array (pointer == DEPTH): beat is accepted and dropped, overflow set. A last beat still finishes the stream; length saturates at DEPTH.
  - Cycle after both fin flags are 1: write_done=1 for exactly one cycle; state -> IDLE in the same cycle.
  - write_en during WRITE is ignored.
- READ:
  - out_X_valid = (rd_ptr_X < len_X); out_X = array[rd_ptr_X] (combinational read); out_X_last = valid & (rd_ptr_X == len_X-1).
  - Pointer advances on valid&ready.
  - When both streams are exhausted: read_done=1 for one cycle, state -> REARM.
  - Both drained in the same cycle: read_done the following cycle.
  - read_en dropping before completion: pause; valids forced 0, pointers held; resume on re-assertion.
- REARM: wait for read_en=0, then IDLE. This covers the controller holding read_en one cycle after read_done. No second read_done is ever produced for one read_en episode.
- Contents persist across reads; repeat reads replay the same tile.
- Read before any write: lengths 0, read_done one cycle after entering READ.
- All inputs sampled on posedge clock; done pulses are registered.

Test Plan:
- Write: write_en pulse, 3 data beats (0x101,0x202,0x303 last) and 2 addr beats (1,3 last) interleaved -> write_done exactly once, one cycle after the later last beat; overflow=0.
- Read: read_en held high, PE ready always -> out_data 0x101,0x202,0x303 (last on 0x303) and out_addr 1,3 (last on 3); read_done one pulse; read_en held high 1 extra cycle -> no second pulse; state returns IDLE after read_en drops.
- Backpressure: out_data_ready toggling 1,0,1,0 -> no word lost or duplicated; read_done only after the final handshake.
- Overflow: 17 addr beats with last on the 17th (ADDR_DEPTH=16) -> overflow=1, length 16, write_done pulses; next write_en clears overflow.
- Reset mid-WRITE after 2 beats -> all outputs 0 next cycle, no write_done; a fresh write_en then completes normally.
- Priority: write_en and read_en both high in IDLE -> WRITE entered, in_*_ready=1, no out_*_valid.
